// File: rtl/score_tracker.sv
// Whack-a-mole score engine: running score with a combo bonus, session high score,
// and a multi-cycle binary-to-BCD conversion of each new record.
module score_tracker #(
   parameter int HIT_POINTS   = 10,
   parameter int MISS_PENALTY = 5,
   parameter int COMBO_THRESH = 5,
   parameter int MAX_SCORE    = 99999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        hit,
   input  logic        miss,
   output logic [23:0] score,
   output logic [23:0] highscore,
   output logic        new_record,
   output logic        playing,
   output logic        busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PLAY    = 2'd1;
   localparam logic [1:0] S_COMPARE = 2'd2;
   localparam logic [1:0] S_CONVERT = 2'd3;

   localparam logic [17:0] LP_HIT    = 18'(HIT_POINTS);
   localparam logic [17:0] LP_BONUS  = 18'(2 * HIT_POINTS);
   localparam logic [17:0] LP_MAX    = 18'(MAX_SCORE);
   localparam logic [16:0] LP_PEN    = 17'(MISS_PENALTY);
   localparam logic [2:0]  LP_THRESH = 3'(COMBO_THRESH);

   logic [1:0]  r_state;
   logic [16:0] r_score;
   logic [16:0] r_hs_bin;
   logic [2:0]  r_streak;
   logic [16:0] r_shift;
   logic [23:0] r_bcd;
   logic [4:0]  r_cnt;
   logic [23:0] r_highscore;
   logic        r_new_record;
   logic        r_hs_load;

   logic [17:0] w_add;
   logic [17:0] w_sum;
   logic [16:0] w_hit_score;
   logic [16:0] w_miss_score;
   logic [2:0]  w_streak_inc;
   logic [23:0] w_bcd_adj;

   // Sum is one bit wider than the score so saturation is decided before any wrap.
   assign w_add        = (r_streak == LP_THRESH) ? LP_BONUS : LP_HIT;
   assign w_sum        = {1'b0, r_score} + w_add;
   assign w_hit_score  = (w_sum > LP_MAX) ? LP_MAX[16:0] : w_sum[16:0];
   assign w_miss_score = (r_score < LP_PEN) ? 17'd0 : r_score - LP_PEN;
   assign w_streak_inc = (r_streak >= LP_THRESH) ? LP_THRESH : r_streak + 3'd1;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_dabble
         assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                       r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_score      <= '0;
         r_hs_bin     <= '0;
         r_streak     <= '0;
         r_shift      <= '0;
         r_bcd        <= '0;
         r_cnt        <= '0;
         r_highscore  <= '0;
         r_new_record <= 1'b0;
         r_hs_load    <= 1'b0;
      end else begin
         r_new_record <= 1'b0;
         r_hs_load    <= 1'b0;
         // The finished accumulator is published one edge after the last shift, all at once.
         if (r_hs_load) r_highscore <= r_bcd;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_PLAY;
                  r_score  <= '0;
                  r_streak <= '0;
               end
            end
            S_PLAY: begin
               if (start) begin
                  r_score  <= '0;
                  r_streak <= '0;
               end else if (stop) begin
                  r_state <= S_COMPARE;
               end else if (miss) begin
                  r_score  <= w_miss_score;
                  r_streak <= '0;
               end else if (hit) begin
                  r_score  <= w_hit_score;
                  r_streak <= w_streak_inc;
               end
            end
            S_COMPARE: begin
               if (r_score > r_hs_bin) begin
                  r_hs_bin     <= r_score;
                  r_shift      <= r_score;
                  r_bcd        <= '0;
                  r_cnt        <= '0;
                  r_new_record <= 1'b1;
                  r_state      <= S_CONVERT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CONVERT: begin
               r_bcd   <= {w_bcd_adj[22:0], r_shift[16]};
               r_shift <= {r_shift[15:0], 1'b0};
               r_cnt   <= r_cnt + 5'd1;
               if (r_cnt == 5'd16) begin
                  r_state   <= S_IDLE;
                  r_hs_load <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign score      = {7'd0, r_score};
   assign highscore  = r_highscore;
   assign new_record = r_new_record;
   assign playing    = (r_state == S_PLAY);
   assign busy       = (r_state == S_COMPARE) || (r_state == S_CONVERT);

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: default instance plus a MAX_SCORE=100 instance.
module tb_score_tracker;

   logic clk = 1'b0;
   logic reset_n;
   logic start, stop, hit, miss;
   logic [23:0] score, highscore;
   logic new_record, playing, busy;

   logic s_start, s_stop, s_hit, s_miss;
   logic [23:0] s_score, s_highscore;
   logic s_new_record, s_playing, s_busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   score_tracker u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .hit(hit), .miss(miss),
      .score(score), .highscore(highscore), .new_record(new_record),
      .playing(playing), .busy(busy)
   );

   score_tracker #(.MAX_SCORE(100)) u_sat (
      .clk(clk), .reset_n(reset_n), .start(s_start), .stop(s_stop), .hit(s_hit), .miss(s_miss),
      .score(s_score), .highscore(s_highscore), .new_record(s_new_record),
      .playing(s_playing), .busy(s_busy)
   );

   task automatic drive_cycle(input logic st, input logic sp, input logic h, input logic m);
      @(negedge clk);
      start = st; stop = sp; hit = h; miss = m;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; hit = 1'b0; miss = 1'b0;
      $display("tx start=%b stop=%b hit=%b miss=%b -> score=%0d playing=%b busy=%b",
               st, sp, h, m, score, playing, busy);
   endtask

   task automatic sat_cycle(input logic st, input logic sp, input logic h);
      @(negedge clk);
      s_start = st; s_stop = sp; s_hit = h; s_miss = 1'b0;
      @(negedge clk);
      s_start = 1'b0; s_stop = 1'b0; s_hit = 1'b0;
      $display("tx sat start=%b stop=%b hit=%b -> score=%0d", st, sp, h, s_score);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      start = 0; stop = 0; hit = 0; miss = 0;
      s_start = 0; s_stop = 0; s_hit = 0; s_miss = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (score !== 24'd0 || highscore !== 24'd0 || new_record !== 1'b0 ||
          playing !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset: score=%0d hs=%h rec=%b play=%b busy=%b, want all 0",
                  score, highscore, new_record, playing, busy);
      end
   endtask

   task automatic test_combo;
      int exp_tab [7] = '{10, 20, 30, 40, 50, 70, 90};
      drive_cycle(1, 0, 0, 0);
      n_vec++;
      if (playing !== 1'b1 || score !== 24'd0) begin
         n_err++;
         $display("FAIL start: playing=%b score=%0d, want 1 and 0", playing, score);
      end
      for (int i = 0; i < 7; i++) begin
         drive_cycle(0, 0, 1, 0);
         n_vec++;
         if (score !== 24'(exp_tab[i])) begin
            n_err++;
            $display("FAIL combo hit%0d: score=%0d want %0d", i + 1, score, exp_tab[i]);
         end
      end
      drive_cycle(0, 0, 0, 1);
      n_vec++;
      if (score !== 24'd85) begin
         n_err++;
         $display("FAIL miss: score=%0d want 85", score);
      end
   endtask

   task automatic test_record;
      int busy_cnt = 0;
      int rec_cnt = 0;
      logic rec_ok = 1'b1;
      drive_cycle(0, 1, 0, 0);
      if (busy === 1'b1) busy_cnt++;
      if (new_record !== 1'b0) rec_ok = 1'b0;
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (new_record === 1'b1) begin
            rec_cnt++;
            if (i != 1) rec_ok = 1'b0;
         end
         if (i == 18) begin
            n_vec++;
            if (highscore !== 24'd0) begin
               n_err++;
               $display("FAIL hs_early: highscore=%h at 18 clocks, want 000000", highscore);
            end
         end
      end
      $display("tx record: busy_cycles=%0d record_pulses=%0d highscore=%h", busy_cnt, rec_cnt, highscore);
      n_vec++;
      if (highscore !== 24'h000085) begin
         n_err++;
         $display("FAIL hs_record: highscore=%h want 000085", highscore);
      end
      n_vec++;
      if (busy_cnt != 18) begin
         n_err++;
         $display("FAIL busy_len: busy cycles=%0d want 18", busy_cnt);
      end
      n_vec++;
      if (rec_cnt != 1 || !rec_ok) begin
         n_err++;
         $display("FAIL new_record: pulses=%0d timing_ok=%b want 1 pulse 1 clock after stop edge",
                  rec_cnt, rec_ok);
      end
      n_vec++;
      if (score !== 24'd85 || playing !== 1'b0) begin
         n_err++;
         $display("FAIL hold: score=%0d playing=%b want 85 and 0", score, playing);
      end
   endtask

   task automatic test_no_record;
      int busy_cnt = 0;
      int rec_cnt = 0;
      drive_cycle(1, 0, 0, 0);
      repeat (5) drive_cycle(0, 0, 1, 0);
      n_vec++;
      if (score !== 24'd50) begin
         n_err++;
         $display("FAIL game2: score=%0d want 50", score);
      end
      drive_cycle(0, 1, 0, 0);
      if (busy === 1'b1) busy_cnt++;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (new_record === 1'b1) rec_cnt++;
      end
      $display("tx no_record: busy_cycles=%0d record_pulses=%0d highscore=%h", busy_cnt, rec_cnt, highscore);
      n_vec++;
      if (busy_cnt != 1 || rec_cnt != 0) begin
         n_err++;
         $display("FAIL no_record: busy=%0d pulses=%0d want 1 and 0", busy_cnt, rec_cnt);
      end
      n_vec++;
      if (highscore !== 24'h000085) begin
         n_err++;
         $display("FAIL hs_keep: highscore=%h want 000085", highscore);
      end
   endtask

   task automatic test_hit_miss;
      drive_cycle(1, 0, 0, 0);
      drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 0, 1, 1);
      n_vec++;
      if (score !== 24'd15) begin
         n_err++;
         $display("FAIL hit_and_miss: score=%0d want 15", score);
      end
      // Streak must be 0: five hits give no bonus, the sixth does.
      repeat (5) drive_cycle(0, 0, 1, 0);
      n_vec++;
      if (score !== 24'd65) begin
         n_err++;
         $display("FAIL streak_clear: score=%0d want 65", score);
      end
      drive_cycle(0, 0, 1, 0);
      n_vec++;
      if (score !== 24'd85) begin
         n_err++;
         $display("FAIL bonus_after: score=%0d want 85", score);
      end
      drive_cycle(1, 0, 0, 0);
      drive_cycle(0, 0, 0, 1);
      n_vec++;
      if (score !== 24'd0) begin
         n_err++;
         $display("FAIL miss_at_0: score=%0d want 0", score);
      end
      drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 0, 0, 1);
      drive_cycle(0, 0, 0, 1);
      n_vec++;
      if (score !== 24'd0) begin
         n_err++;
         $display("FAIL underflow: score=%0d want 0", score);
      end
      drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 1, 0, 0);
      repeat (3) @(negedge clk);
      repeat (3) drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 0, 0, 1);
      n_vec++;
      if (score !== 24'd10 || playing !== 1'b0 || highscore !== 24'h000085) begin
         n_err++;
         $display("FAIL idle_ignore: score=%0d playing=%b hs=%h want 10 0 000085",
                  score, playing, highscore);
      end
   endtask

   task automatic test_saturation;
      int exp_tab [12] = '{10, 20, 30, 40, 50, 70, 90, 100, 100, 100, 100, 100};
      int bad = 0;
      sat_cycle(1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         sat_cycle(0, 0, 1);
         if (s_score !== 24'(exp_tab[i])) begin
            bad++;
            $display("FAIL sat_hit%0d: score=%0d want %0d", i + 1, s_score, exp_tab[i]);
         end
      end
      n_vec++;
      if (bad != 0) n_err++;
      sat_cycle(0, 1, 0);
      repeat (20) @(negedge clk);
      n_vec++;
      if (s_highscore !== 24'h000100) begin
         n_err++;
         $display("FAIL sat_hs: highscore=%h want 000100", s_highscore);
      end
   endtask

   task automatic test_reset_mid_convert;
      int play_bad = 0;
      drive_cycle(1, 0, 0, 0);
      repeat (10) drive_cycle(0, 0, 1, 0);
      n_vec++;
      if (score !== 24'd150) begin
         n_err++;
         $display("FAIL game3: score=%0d want 150", score);
      end
      drive_cycle(0, 1, 0, 0);
      repeat (9) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      $display("tx async reset mid-convert: score=%0d hs=%h busy=%b", score, highscore, busy);
      n_vec++;
      if (highscore !== 24'd0 || busy !== 1'b0 || playing !== 1'b0 || score !== 24'd0) begin
         n_err++;
         $display("FAIL reset_convert: hs=%h busy=%b play=%b score=%0d want 0 0 0 0",
                  highscore, busy, playing, score);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (25) @(negedge clk);
      n_vec++;
      if (highscore !== 24'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL discard: hs=%h busy=%b want 000000 0", highscore, busy);
      end
      drive_cycle(1, 0, 0, 0);
      drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 1, 0, 0);
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         start = (i == 3);
         stop  = (i == 4);
         if (i >= 3 && playing !== 1'b0) play_bad++;
      end
      $display("tx pulses during convert: playing_violations=%0d hs=%h", play_bad, highscore);
      n_vec++;
      if (play_bad != 0 || playing !== 1'b0) begin
         n_err++;
         $display("FAIL convert_ignore: playing violations=%0d want 0", play_bad);
      end
      n_vec++;
      if (highscore !== 24'h000010) begin
         n_err++;
         $display("FAIL hs_after_ignore: highscore=%h want 000010", highscore);
      end
   endtask

   initial begin
      test_reset;
      test_combo;
      test_record;
      test_no_record;
      test_hit_miss;
      test_saturation;
      test_reset_mid_convert;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
